// File: rtl/mcs8_pc_stack_ctrl.sv
// Program-counter / circular call-stack sequencer for the MCS8 core: drives the fetch address and
// redirects fetch on JMP/CALL/RET/RST. Define MCS8_STACK_CHK_EN to add stack over/underflow checking (STK_ERR_O).
module mcs8_pc_stack_ctrl #(
    parameter int AW           = 14,
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic          CLK_I,
    input  logic          nRST_I,
    input  logic          STALL_I,
    input  logic          CMD_VALID_I,
    output logic          CMD_READY_O,
    input  logic [2:0]    CMD_I,
    input  logic          COND_I,
    input  logic [AW-1:0] TGT_I,
    input  logic [2:0]    RST_VEC_I,
    input  logic [AW-1:0] RET_ADDR_I,
    output logic [AW-1:0] I_ADDR_O,
    output logic          FETCH_VALID_O,
    output logic          FLUSH_O
`ifdef MCS8_STACK_CHK_EN
    ,
    output logic          STK_ERR_O
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(FLUSH_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ndx_q, ndx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] stack_q [DEPTH];
    logic [AW-1:0] stack_d [DEPTH];

    logic          is_jmp_s, is_call_s, is_ret_s, is_rst_s;
    logic          want_s, drop_s, taken_s;
    logic [IW-1:0] ndx_inc_s, ndx_dec_s;
    logic [AW-1:0] push_tgt_s;

`ifdef MCS8_STACK_CHK_EN
    localparam logic [IW-1:0] DEPTH_MAX = IW'(DEPTH - 1);
    logic [IW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
`endif

    // Command decode; RST is taken regardless of COND_I, codes 5-7 behave as NOP.
    always_comb begin
        is_jmp_s  = 1'b0;
        is_call_s = 1'b0;
        is_ret_s  = 1'b0;
        is_rst_s  = 1'b0;
        case (CMD_I)
            3'd1:    is_jmp_s  = 1'b1;
            3'd2:    is_call_s = 1'b1;
            3'd3:    is_ret_s  = 1'b1;
            3'd4:    is_rst_s  = 1'b1;
            default: is_jmp_s  = 1'b0;
        endcase
        want_s = CMD_VALID_I && (state_q == ST_RUN) &&
                 (is_rst_s || (COND_I && (is_jmp_s || is_call_s || is_ret_s)));
`ifdef MCS8_STACK_CHK_EN
        if ((is_call_s || is_rst_s) && (depth_q == DEPTH_MAX)) begin
            drop_s = want_s;
        end else if (is_ret_s && (depth_q == {IW{1'b0}})) begin
            drop_s = want_s;
        end else begin
            drop_s = 1'b0;
        end
`else
        drop_s = 1'b0;
`endif
        taken_s    = want_s && !drop_s;
        ndx_inc_s  = ndx_q + IW'(1);
        ndx_dec_s  = ndx_q - IW'(1);
        push_tgt_s = is_rst_s ? {{(AW-6){1'b0}}, RST_VEC_I, 3'b000} : TGT_I;
    end

    // Sequencer next-state, stack update and output decode.
    always_comb begin
        state_d       = state_q;
        ndx_d         = ndx_q;
        cnt_d         = cnt_q;
        stack_d       = stack_q;
        CMD_READY_O   = 1'b0;
        FETCH_VALID_O = 1'b0;
        FLUSH_O       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                CMD_READY_O   = 1'b1;
                FETCH_VALID_O = !STALL_I;
                if (taken_s) begin
                    state_d = ST_REDIRECT;
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                    if (is_jmp_s) begin
                        stack_d[ndx_q] = TGT_I;
                    end else if (is_ret_s) begin
                        ndx_d = ndx_dec_s;
                    end else begin
                        stack_d[ndx_q]     = RET_ADDR_I;
                        stack_d[ndx_inc_s] = push_tgt_s;
                        ndx_d              = ndx_inc_s;
                    end
                end else if (!STALL_I) begin
                    stack_d[ndx_q] = stack_q[ndx_q] + AW'(1);
                end else begin
                    stack_d[ndx_q] = stack_q[ndx_q];
                end
            end
            ST_REDIRECT: begin
                FLUSH_O = 1'b1;
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign I_ADDR_O = stack_q[ndx_q];

    // State, index, flush counter and stack registers.
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state_q <= ST_IDLE;
            ndx_q   <= {IW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= {AW{1'b0}};
            end
        end else begin
            state_q <= state_d;
            ndx_q   <= ndx_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

`ifdef MCS8_STACK_CHK_EN
    // Depth tracking; an overflowing CALL/RST or underflowing RET is dropped and latched as an error.
    always_comb begin
        err_d = err_q || drop_s;
        if (taken_s && (is_call_s || is_rst_s)) begin
            depth_d = depth_q + IW'(1);
        end else if (taken_s && is_ret_s) begin
            depth_d = depth_q - IW'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    // Depth counter and sticky error flag registers.
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            depth_q <= {IW{1'b0}};
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign STK_ERR_O = err_q;
`endif

endmodule

// File: tb/tb_mcs8_pc_stack_ctrl.sv
// Self-checking bench for mcs8_pc_stack_ctrl: abstract PC/stack model compared every cycle,
// plus hand-computed address pins along a directed command sequence.
module tb_mcs8_pc_stack_ctrl;

    localparam int AW    = 14;
    localparam int DEPTH = 8;
    localparam int FLUSH = 3;
`ifdef MCS8_STACK_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd;
    logic          cond;
    logic [AW-1:0] tgt;
    logic [2:0]    rst_vec;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] i_addr;
    logic          fetch_valid;
    logic          flush;
`ifdef MCS8_STACK_CHK_EN
    logic          stk_err;
    int            pin_err;
`endif

    always #5 clk = ~clk;

    mcs8_pc_stack_ctrl #(.AW(AW), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
        .CLK_I        (clk),
        .nRST_I       (rst_n),
        .STALL_I      (stall),
        .CMD_VALID_I  (cmd_valid),
        .CMD_READY_O  (cmd_ready),
        .CMD_I        (cmd),
        .COND_I       (cond),
        .TGT_I        (tgt),
        .RST_VEC_I    (rst_vec),
        .RET_ADDR_I   (ret_addr),
        .I_ADDR_O     (i_addr),
        .FETCH_VALID_O(fetch_valid),
        .FLUSH_O      (flush)
`ifdef MCS8_STACK_CHK_EN
        ,
        .STK_ERR_O    (stk_err)
`endif
    );

    // Abstract model: a stack of PCs, a stack pointer, flush cycles left, a "started" flag.
    int m_stk [DEPTH];
    int m_sp;
    int m_flush;
    int m_depth;
    bit m_live;
    bit m_err;

    int errors = 0;
    int checks = 0;
    bit pin_en = 1'b0;
    int pin_addr = 0;
    int pin_sp = -1;

    function automatic bit f_taken(input logic [2:0] c, input logic cd);
        return (c == 3'd4) || (cd && (c == 3'd1 || c == 3'd2 || c == 3'd3));
    endfunction

    function automatic bit f_drop(input logic [2:0] c, input int depth);
        return CHK && ((((c == 3'd2) || (c == 3'd4)) && depth == DEPTH - 1) ||
                       ((c == 3'd3) && depth == 0));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_stk[i] <= 0;
            m_sp    <= 0;
            m_flush <= 0;
            m_depth <= 0;
            m_live  <= 1'b0;
            m_err   <= 1'b0;
        end else if (!m_live) begin
            m_live <= 1'b1;
        end else if (m_flush > 0) begin
            m_flush <= m_flush - 1;
        end else if (cmd_valid && f_taken(cmd, cond) && !f_drop(cmd, m_depth)) begin
            m_flush <= FLUSH;
            if (cmd == 3'd1) begin
                m_stk[m_sp] <= int'(tgt);
            end else if (cmd == 3'd3) begin
                m_sp    <= (m_sp + DEPTH - 1) % DEPTH;
                m_depth <= m_depth - 1;
            end else begin
                m_stk[m_sp] <= int'(ret_addr);
                m_stk[(m_sp + 1) % DEPTH] <= (cmd == 3'd4) ? int'(rst_vec) * 8 : int'(tgt);
                m_sp    <= (m_sp + 1) % DEPTH;
                m_depth <= m_depth + 1;
            end
        end else begin
            if (cmd_valid && f_taken(cmd, cond)) m_err <= 1'b1;
            if (!stall) m_stk[m_sp] <= (m_stk[m_sp] + 1) % (1 << AW);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Single compare process: DUT against model every cycle, plus hand-computed pins.
    always @(negedge clk) begin
        chk("i_addr", int'(i_addr), m_stk[m_sp]);
        chk("flush", int'(flush), (m_flush > 0) ? 1 : 0);
        chk("cmd_ready", int'(cmd_ready), (m_live && m_flush == 0) ? 1 : 0);
        chk("fetch_valid", int'(fetch_valid), (m_live && m_flush == 0 && !stall) ? 1 : 0);
`ifdef MCS8_STACK_CHK_EN
        chk("stk_err", int'(stk_err), int'(m_err));
        if (pin_err >= 0) chk("pin_stk_err", int'(stk_err), pin_err);
`endif
        if (pin_en) begin
            chk("pin_dut_addr", int'(i_addr), pin_addr);
            chk("pin_model_addr", m_stk[m_sp], pin_addr);
            if (pin_sp >= 0) chk("pin_model_sp", m_sp, pin_sp);
        end
    end

    task automatic tick(input int addr, input int sp);
        pin_addr = addr;
        pin_sp   = sp;
        pin_en   = 1'b1;
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic tick_nc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic cd, input logic [AW-1:0] t,
                        input logic [AW-1:0] r, input logic [2:0] v);
        cmd_valid = 1'b1;
        cmd       = c;
        cond      = cd;
        tgt       = t;
        ret_addr  = r;
        rst_vec   = v;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        cond      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; cond = 1'b0;
        tgt = 14'h0; rst_vec = 3'd0; ret_addr = 14'h0;
`ifdef MCS8_STACK_CHK_EN
        pin_err = -1;
`endif
        @(posedge clk); #1;
        tick(0, 0); tick(0, 0);
        // T1: one IDLE cycle, then counting from 0
        rst_n = 1'b1;
        tick(0, 0); tick(0, 0); tick(1, 0); tick(2, 0);
        // T2: JMP
        send(3'd1, 1'b1, 14'h1234, 14'h0, 3'd0); tick(3, 0); idle();
        repeat (4) tick('h1234, 0);
        tick('h1235, 0);
        // T3: CALL then RET
        send(3'd2, 1'b1, 14'h0200, 14'h0045, 3'd0); tick('h1236, 0); idle();
        repeat (4) tick('h0200, 1);
        tick('h0201, 1);
        send(3'd3, 1'b1, 14'h0, 14'h0, 3'd0); tick('h0202, 1); idle();
        repeat (4) tick('h0045, 0);
        tick('h0046, 0);
        // T4: RST ignores COND, JMP with COND=0 is not taken, RET back
        send(3'd4, 1'b0, 14'h0, 14'h0048, 3'd5); tick('h0047, 0); idle();
        repeat (4) tick('h0028, 1);
        send(3'd1, 1'b0, 14'h3FFF, 14'h0, 3'd0); tick('h0029, 1); idle();
        tick('h002A, 1);
        send(3'd3, 1'b1, 14'h0, 14'h0, 3'd0); tick('h002B, 1); idle();
        repeat (4) tick('h0048, 0);
        // PC wrap 3FFF -> 0000
        send(3'd1, 1'b1, 14'h3FFE, 14'h0, 3'd0); tick('h0049, 0); idle();
        repeat (4) tick('h3FFE, 0);
        tick('h3FFF, 0); tick(0, 0);
        // T6b: stall holds the PC, but a taken JMP still redirects
        stall = 1'b1;
        tick(1, 0); tick(1, 0);
        send(3'd1, 1'b1, 14'h0100, 14'h0, 3'd0); tick(1, 0); idle();
        repeat (4) tick('h0100, 0);
        stall = 1'b0;
        tick('h0100, 0); tick('h0101, 0);
        // Undefined code and NOP are consumed without redirect
        send(3'd5, 1'b1, 14'h2000, 14'h0, 3'd0); tick('h0102, 0);
        send(3'd0, 1'b1, 14'h2000, 14'h0, 3'd0); tick('h0103, 0); idle();
        tick('h0104, 0);
        // T5: eight nested CALLs, then eight RETs
        for (int k = 0; k < DEPTH; k++) begin
            send(3'd2, 1'b1, 14'(16'h1000 + k * 16), 14'(16'h0700 + k), 3'd0);
            tick_nc(); idle();
            repeat (4) tick_nc();
        end
        for (int k = 0; k < DEPTH; k++) begin
            send(3'd3, 1'b1, 14'h0, 14'h0, 3'd0);
            tick_nc(); idle();
            repeat (4) tick_nc();
        end
`ifdef MCS8_STACK_CHK_EN
        pin_err = 1;
        tick_nc();
        pin_err = -1;
`else
        tick('h1072, 0);
`endif
        // T6: reset asserted mid-redirect clears everything in the same cycle
        send(3'd1, 1'b1, 14'h2222, 14'h0, 3'd0); tick_nc(); idle();
        tick('h2222, -1);
        rst_n = 1'b0;
        tick(0, 0); tick(0, 0);
        rst_n = 1'b1;
        tick(0, 0); tick(0, 0); tick(1, 0);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
